// File: rtl/fgp_fb_writer_if.sv
// Payload-stream-to-framebuffer bus: fgp_rx offset/byte stream in, RAM write port
// and status out.
interface fgp_fb_writer_if #(
  parameter int ADDR_WIDTH  = 17,
  parameter int COLOR_WIDTH = 12
);
  logic                   setoff_req;
  logic [ADDR_WIDTH-1:0]  setoff_val;
  logic                   inclk;
  logic [7:0]             in;
  logic                   in_done;
  logic                   we;
  logic [ADDR_WIDTH-1:0]  waddr;
  logic [COLOR_WIDTH-1:0] wdata;
  logic                   pkt_done;
  logic                   err;

  modport master (
    output setoff_req, setoff_val, inclk, in, in_done,
    input  we, waddr, wdata, pkt_done, err
  );

  modport slave (
    input  setoff_req, setoff_val, inclk, in, in_done,
    output we, waddr, wdata, pkt_done, err
  );
endinterface

// File: rtl/fgp_fb_writer.sv
// Unpacks the fgp_rx payload stream (3 bytes -> 2 colours of 12 bits) into
// framebuffer RAM writes at base + colour index.
module fgp_fb_writer #(
  parameter int COLOR_WIDTH = 12,
  parameter int ADDR_WIDTH  = 17,
  parameter int FB_DEPTH    = 76800,
  parameter int PKT_COLORS  = 512
) (
  input logic            clk,
  input logic            rst,
  fgp_fb_writer_if.slave bus
);

  localparam int IDX_W = $clog2(PKT_COLORS + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PKT_COLORS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_COLORS - 1);
  localparam logic [ADDR_WIDTH:0] FB_LIMIT = (ADDR_WIDTH + 1)'(FB_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  base, base_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [1:0]             phase, phase_nx;
  logic [7:0]             hold_byte, hold_byte_nx;
  logic [3:0]             hold_nib, hold_nib_nx;

  logic                   accept, colour_done, in_fb, err_set;
  logic [ADDR_WIDTH:0]    addr_sum;
  logic [COLOR_WIDTH-1:0] colour;

  logic                   we_d, pkt_done_d, err_d;
  logic [ADDR_WIDTH-1:0]  waddr_d;
  logic [COLOR_WIDTH-1:0] wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      phase     <= '0;
      hold_byte <= '0;
      hold_nib  <= '0;
    end else begin
      state     <= state_nx;
      base      <= base_nx;
      idx       <= idx_nx;
      phase     <= phase_nx;
      hold_byte <= hold_byte_nx;
      hold_nib  <= hold_nib_nx;
    end
  end

  // A byte is decoded only when armed, not full, and not pre-empted by a new offset.
  assign accept      = bus.inclk && !bus.setoff_req && (state == ACTIVE) && (idx != IDX_FULL);
  assign colour_done = accept && (phase != 2'd0);
  assign colour      = (phase == 2'd1) ? {hold_byte, bus.in[7:4]} : {hold_nib, bus.in};
  assign addr_sum    = {1'b0, base} + (ADDR_WIDTH + 1)'(idx);
  assign in_fb       = addr_sum < FB_LIMIT;

  assign err_set =
      (bus.setoff_req && (bus.inclk || (state == ACTIVE && (idx != '0 || phase != 2'd0))))
   || (!bus.setoff_req && bus.inclk && (state == IDLE || idx == IDX_FULL))
   || (accept && bus.in_done && !(phase == 2'd2 && idx == IDX_LAST));

  always_comb begin
    state_nx     = state;
    base_nx      = base;
    idx_nx       = idx;
    phase_nx     = phase;
    hold_byte_nx = hold_byte;
    hold_nib_nx  = hold_nib;
    if (bus.setoff_req) begin
      state_nx = ACTIVE;
      base_nx  = bus.setoff_val;
      idx_nx   = '0;
      phase_nx = 2'd0;
    end else if (accept) begin
      case (phase)
        2'd0: begin
          hold_byte_nx = bus.in;
          phase_nx     = 2'd1;
        end
        2'd1: begin
          hold_nib_nx = bus.in[3:0];
          phase_nx    = 2'd2;
          idx_nx      = idx + IDX_W'(1);
        end
        default: begin
          phase_nx = 2'd0;
          idx_nx   = idx + IDX_W'(1);
        end
      endcase
      if (bus.in_done) state_nx = IDLE;
    end
  end

  // Colours landing beyond the visible framebuffer still consume an index but never write.
  always_comb begin
    we_d       = colour_done && in_fb;
    waddr_d    = bus.waddr;
    wdata_d    = bus.wdata;
    pkt_done_d = accept && bus.in_done;
    err_d      = bus.err || err_set;
    if (colour_done && in_fb) begin
      waddr_d = addr_sum[ADDR_WIDTH-1:0];
      wdata_d = colour;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      bus.pkt_done <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.we       <= we_d;
      bus.waddr    <= waddr_d;
      bus.wdata    <= wdata_d;
      bus.pkt_done <= pkt_done_d;
      bus.err      <= err_d;
    end
  end

endmodule

// File: tb/tb_fgp_fb_writer.sv
// Bench for fgp_fb_writer: packet-level byte model checked every cycle, plus
// directed packets with literal expectations.
module tb_fgp_fb_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fgp_fb_writer_if #(.ADDR_WIDTH(17), .COLOR_WIDTH(12)) bus ();

  fgp_fb_writer #(
    .COLOR_WIDTH(12), .ADDR_WIDTH(17), .FB_DEPTH(76800), .PKT_COLORS(512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  bit         model_valid = 1'b0;
  bit         m_active = 1'b0;
  int         m_n = 0;
  int         m_base = 0;
  logic [7:0] m_bytes [768];
  logic        exp_we = 1'b0, exp_pkt_done = 1'b0, exp_err = 1'b0;
  logic [16:0] exp_waddr = '0;
  logic [11:0] exp_wdata = '0;

  logic [16:0] log_addr [$];
  logic [11:0] log_data [$];
  int          pkt_count = 0;
  int          pkt_at_write = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] modelColour(input int c);
    int j;
    logic [7:0] b0, b1, b2;
    j  = 3 * (c / 2);
    b0 = m_bytes[j];
    b1 = m_bytes[j + 1];
    b2 = (c % 2 == 1) ? m_bytes[j + 2] : 8'h00;
    return (c % 2 == 0) ? {b0, b1[7:4]} : {b1[3:0], b2};
  endfunction

  function automatic logic [7:0] patByte(input int i);
    case (i % 3)
      0:       return 8'h12;
      1:       return 8'h34;
      default: return 8'h56;
    endcase
  endfunction

  // Packet-level model: byte n of a packet completes colour 2*(n/3)+(n%3)-1 when n%3 != 0.
  task automatic modelStep();
    int c;
    int addr;
    exp_we       = 1'b0;
    exp_pkt_done = 1'b0;
    if (rst) begin
      m_active    = 1'b0;
      m_n         = 0;
      m_base      = 0;
      exp_err     = 1'b0;
      model_valid = 1'b1;
    end else if (bus.setoff_req) begin
      if (bus.inclk || (m_active && m_n != 0)) exp_err = 1'b1;
      m_base   = int'(bus.setoff_val);
      m_n      = 0;
      m_active = 1'b1;
    end else if (bus.inclk) begin
      if (!m_active || m_n == 768) begin
        exp_err = 1'b1;
      end else begin
        m_bytes[m_n] = bus.in;
        if (m_n % 3 != 0) begin
          c    = 2 * (m_n / 3) + (m_n % 3) - 1;
          addr = m_base + c;
          if (addr < 76800) begin
            exp_we    = 1'b1;
            exp_waddr = 17'(addr);
            exp_wdata = modelColour(c);
          end
        end
        m_n++;
        if (bus.in_done) begin
          exp_pkt_done = 1'b1;
          m_active     = 1'b0;
          if (m_n != 768) exp_err = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison against the model, plus a write log for literal checks.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      checkOutput("we", bus.we, exp_we);
      checkOutput("pkt_done", bus.pkt_done, exp_pkt_done);
      checkOutput("err", bus.err, exp_err);
      if (exp_we) begin
        checkOutput("waddr", bus.waddr, exp_waddr);
        checkOutput("wdata", bus.wdata, exp_wdata);
      end
      if (bus.we === 1'b1) begin
        log_addr.push_back(bus.waddr);
        log_data.push_back(bus.wdata);
      end
      if (bus.pkt_done === 1'b1) begin
        pkt_count++;
        pkt_at_write = log_addr.size();
      end
    end
  end

  task automatic applyStimulus(input logic so, input logic [16:0] sv, input logic ic,
                               input logic [7:0] b, input logic done);
    @(negedge clk);
    bus.setoff_req = so;
    bus.setoff_val = sv;
    bus.inclk      = ic;
    bus.in         = b;
    bus.in_done    = done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.setoff_req = 1'b0;
    bus.inclk      = 1'b0;
    bus.in_done    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_we", bus.we, 0);
    checkOutput("rst_waddr", bus.waddr, 0);
    checkOutput("rst_wdata", bus.wdata, 0);
    checkOutput("rst_pkt_done", bus.pkt_done, 0);
    checkOutput("rst_err", bus.err, 0);
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
    pkt_count    = 0;
    pkt_at_write = -1;
  endtask

  task automatic sendPacket(input logic [16:0] base, input int nbytes, input bit with_done);
    applyStimulus(1'b1, base, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < nbytes; i++)
      applyStimulus(1'b0, '0, 1'b1, patByte(i), with_done && (i == nbytes - 1));
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.setoff_req = 1'b0;
    bus.setoff_val = '0;
    bus.inclk      = 1'b0;
    bus.in         = '0;
    bus.in_done    = 1'b0;

    $display("[TB] reset");
    doReset();

    $display("[TB] full packet at offset 1");
    clearLog();
    sendPacket(17'h00200, 768, 1'b1);
    checkOutput("t1_count", log_addr.size(), 512);
    checkOutput("t1_addr0", log_addr[0], 17'h00200);
    checkOutput("t1_data0", log_data[0], 12'h123);
    checkOutput("t1_data1", log_data[1], 12'h456);
    checkOutput("t1_addr511", log_addr[511], 17'h003FF);
    checkOutput("t1_data511", log_data[511], 12'h456);
    checkOutput("t1_pkt_count", pkt_count, 1);
    checkOutput("t1_pkt_at_write", pkt_at_write, 512);
    checkOutput("t1_err", bus.err, 0);

    $display("[TB] write latency");
    applyStimulus(1'b1, 17'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'hAB, 1'b0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'hCD, 1'b0);
    checkOutput("t2_no_write_b0", bus.we, 0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'hEF, 1'b0);
    checkOutput("t2_we_c0", bus.we, 1);
    checkOutput("t2_addr_c0", bus.waddr, 17'h0);
    checkOutput("t2_data_c0", bus.wdata, 12'hABC);
    idle(1);
    checkOutput("t2_we_c1", bus.we, 1);
    checkOutput("t2_addr_c1", bus.waddr, 17'h1);
    checkOutput("t2_data_c1", bus.wdata, 12'hDEF);
    idle(1);
    checkOutput("t2_we_off", bus.we, 0);
    checkOutput("t2_err", bus.err, 0);

    $display("[TB] framebuffer edge");
    doReset();
    clearLog();
    sendPacket(17'(149 * 512), 768, 1'b1);
    checkOutput("t3_count149", log_addr.size(), 512);
    checkOutput("t3_first149", log_addr[0], 17'd76288);
    checkOutput("t3_last149", log_addr[511], 17'd76799);
    clearLog();
    sendPacket(17'(150 * 512), 768, 1'b1);
    checkOutput("t3_count150", log_addr.size(), 0);
    checkOutput("t3_pkt150", pkt_count, 1);
    checkOutput("t3_err", bus.err, 0);

    $display("[TB] protocol errors");
    doReset();
    clearLog();
    applyStimulus(1'b0, 17'h0, 1'b1, 8'h55, 1'b0);
    idle(2);
    checkOutput("t4_stray_err", bus.err, 1);
    checkOutput("t4_stray_nowrite", log_addr.size(), 0);
    doReset();
    sendPacket(17'h00400, 100, 1'b0);
    checkOutput("t4_partial_err0", bus.err, 0);
    clearLog();
    sendPacket(17'h00600, 3, 1'b0);
    checkOutput("t4_abandon_err", bus.err, 1);
    checkOutput("t4_new_count", log_addr.size(), 2);
    checkOutput("t4_new_addr0", log_addr[0], 17'h00600);
    checkOutput("t4_new_data0", log_data[0], 12'h123);
    checkOutput("t4_new_addr1", log_addr[1], 17'h00601);

    $display("[TB] overrun and short packet");
    doReset();
    clearLog();
    sendPacket(17'h0, 768, 1'b0);
    checkOutput("t5_full_count", log_addr.size(), 512);
    checkOutput("t5_full_err", bus.err, 0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'h99, 1'b0);
    idle(2);
    checkOutput("t5_overrun_err", bus.err, 1);
    checkOutput("t5_overrun_nowrite", log_addr.size(), 512);
    clearLog();
    sendPacket(17'h0, 300, 1'b1);
    checkOutput("t5_short_pkt", pkt_count, 1);
    checkOutput("t5_short_pkt_at", pkt_at_write, 200);
    checkOutput("t5_short_count", log_addr.size(), 200);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'h22, 1'b0);
    idle(2);
    checkOutput("t5_idle_nowrite", log_addr.size(), 200);

    $display("[TB] reset mid-colour");
    doReset();
    clearLog();
    applyStimulus(1'b1, 17'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 17'h0, 1'b1, 8'h12, 1'b0);
    doReset();
    checkOutput("t6_nowrite", log_addr.size(), 0);
    sendPacket(17'h00200, 3, 1'b0);
    checkOutput("t6_count", log_addr.size(), 2);
    checkOutput("t6_addr0", log_addr[0], 17'h00200);
    checkOutput("t6_data0", log_data[0], 12'h123);
    checkOutput("t6_data1", log_data[1], 12'h456);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
